// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, bubble word and
// the ID/EX pipeline register layout for the default 16-bit datapath.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 16;
  localparam logic [15:0] BUBBLE_INSTR_DEF = 16'h000F;

  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned OP_MSB    = 3;
  localparam int unsigned IMM_BIT   = 4;
  localparam int unsigned RX_LSB    = 5;
  localparam int unsigned RX_MSB    = 7;
  localparam int unsigned RY_LSB    = 8;
  localparam int unsigned RY_MSB    = 10;
  localparam int unsigned IMM8_LSB  = 8;
  localparam int unsigned IMM11_LSB = 5;
  localparam int unsigned INSTR_MSB = 15;

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_ST   = 4'd4,
    OP_LD   = 4'd5,
    OP_MVHI = 4'd6,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_JNZ  = 4'd10,
    OP_CALL = 4'd12
  } opcode_e;

  typedef struct packed {
    logic                  valid;
    logic [15:0]           instr;
    logic [CPU_DATA_W-1:0] pc;
    logic [CPU_DATA_W-1:0] opx;
    logic [CPU_DATA_W-1:0] opy;
    logic [CPU_DATA_W-1:0] imm;
  } id_ex_t;

endpackage

// File: rtl/cpu_src_use.sv
// Opcode decode for the read side: which of Rx/Ry an instruction reads and its
// sign-extended immediate.
module cpu_src_use
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [15:0]       instr,
  output logic              use_x,
  output logic              use_y,
  output logic [DATA_W-1:0] imm
);

  logic        is_imm;
  logic [7:0]  imm8;
  logic [10:0] imm11;
  logic [DATA_W-1:0] sext_imm8;
  logic [DATA_W-1:0] jmp_imm;

  assign is_imm    = instr[IMM_BIT];
  assign imm8      = instr[INSTR_MSB:IMM8_LSB];
  assign imm11     = instr[INSTR_MSB:IMM11_LSB];
  assign sext_imm8 = {{(DATA_W-8){imm8[7]}}, imm8};
  assign jmp_imm   = {{(DATA_W-12){imm11[10]}}, imm11, 1'b0};

  always_comb begin
    use_x = 1'b0;
    use_y = 1'b0;
    imm   = '0;
    case (instr[OP_MSB:OP_LSB])
      OP_MV: begin
        use_y = !is_imm;
        imm   = sext_imm8;
      end
      OP_ADD, OP_SUB, OP_CMP: begin
        use_x = 1'b1;
        use_y = !is_imm;
        imm   = sext_imm8;
      end
      OP_ST: begin
        use_x = 1'b1;
        use_y = 1'b1;
        imm   = sext_imm8;
      end
      OP_LD: begin
        use_y = 1'b1;
        imm   = sext_imm8;
      end
      OP_MVHI: begin
        use_x = 1'b1;
        imm   = sext_imm8;
      end
      OP_JMP, OP_JZ, OP_JNZ, OP_CALL: begin
        use_x = !is_imm;
        imm   = jmp_imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_rf_read.sv
// Register-file read / operand-fetch stage with RAW hazard resolution and the
// ID/EX pipeline register. Define CPU_RF_FWD_EN to enable EX/WB forwarding.
module cpu_rf_read
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter logic [15:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              in_ready,
  output logic [2:0]        rf_raddr_x,
  output logic [2:0]        rf_raddr_y,
  input  logic [DATA_W-1:0] rf_rdata_x,
  input  logic [DATA_W-1:0] rf_rdata_y,
  input  logic              ex_wr,
  input  logic [2:0]        ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_ld,
  input  logic              wb_wr,
  input  logic [2:0]        wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_ld_r7,
  input  logic [DATA_W-1:0] wb_r7_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_opx,
  output logic [DATA_W-1:0] out_opy,
  output logic [DATA_W-1:0] out_imm
);

  typedef struct packed {
    logic              valid;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] opx;
    logic [DATA_W-1:0] opy;
    logic [DATA_W-1:0] imm;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, instr: BUBBLE_INSTR, default: '0};

  logic [2:0]        rx;
  logic [2:0]        ry;
  logic              use_x;
  logic              use_y;
  logic [DATA_W-1:0] imm;
  logic              hazard;
  logic [DATA_W-1:0] opx;
  logic [DATA_W-1:0] opy;
  stage_t            stage_q;

  assign rx         = in_instr[RX_MSB:RX_LSB];
  assign ry         = in_instr[RY_MSB:RY_LSB];
  assign rf_raddr_x = rx;
  assign rf_raddr_y = ry;

  cpu_src_use #(.DATA_W(DATA_W)) u_src_use (
    .instr (in_instr),
    .use_x (use_x),
    .use_y (use_y),
    .imm   (imm)
  );

`ifdef CPU_RF_FWD_EN
  // A load in EX has no result yet; everything else is forwarded by priority.
  function automatic logic ld_pending(input logic [2:0] s);
    return ex_wr && ex_is_ld && (ex_waddr == s);
  endfunction

  function automatic logic [DATA_W-1:0] fwd_operand(input logic [2:0] s,
                                                    input logic [DATA_W-1:0] rf_data);
    if (ex_wr && !ex_is_ld && (ex_waddr == s)) return ex_wdata;
    if (wb_ld_r7 && (s == 3'd7))               return wb_r7_data;
    if (wb_wr && (wb_waddr == s))              return wb_wdata;
    return rf_data;
  endfunction

  always_comb begin
    hazard = in_valid && ((use_x && ld_pending(rx)) || (use_y && ld_pending(ry)));
    opx    = use_x ? fwd_operand(rx, rf_rdata_x) : '0;
    opy    = use_y ? fwd_operand(ry, rf_rdata_y) : '0;
  end
`else
  // Without forwarding, wait until no in-flight write targets a used source.
  function automatic logic write_pending(input logic [2:0] s);
    return (ex_wr && (ex_waddr == s)) || (wb_wr && (wb_waddr == s)) ||
           (wb_ld_r7 && (s == 3'd7));
  endfunction

  always_comb begin
    hazard = in_valid && ((use_x && write_pending(rx)) || (use_y && write_pending(ry)));
    opx    = use_x ? rf_rdata_x : '0;
    opy    = use_y ? rf_rdata_y : '0;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_wdata, ex_is_ld, wb_wdata, wb_r7_data};
`endif

  assign in_ready = flush || (!ex_stall && !hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= BUBBLE;
    end else if (flush) begin
      stage_q <= BUBBLE;
    end else if (!ex_stall) begin
      if (in_valid && !hazard) begin
        stage_q <= '{valid: 1'b1, instr: in_instr, pc: in_pc, opx: opx, opy: opy, imm: imm};
      end else begin
        stage_q <= BUBBLE;
      end
    end
  end

  assign out_valid = stage_q.valid;
  assign out_instr = stage_q.instr;
  assign out_pc    = stage_q.pc;
  assign out_opx   = stage_q.opx;
  assign out_opy   = stage_q.opy;
  assign out_imm   = stage_q.imm;

endmodule

// File: doc/cpu_rf_read.md
Name: cpu_rf_read

Overview:
Register-file read / operand-fetch stage of the 16-bit pipelined CPU. It is the read-side counterpart of the write-back control decode.
- Decodes which of Rx/Ry each instruction reads and drives the external register-file read addresses.
- Resolves RAW hazards by forwarding from EX and WB, or by stalling.
- Registers operands, immediate, PC and instruction into the ID/EX pipeline register.

Parameters:
DATA_W, 16, operand/PC width
BUBBLE_INSTR, 16'h000F, instruction word injected into EX on stall or flush (opcode 15, no RF write)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
in_valid  in  1  fetch presents an instruction
in_instr  in  16  instruction: op=[3:0], imm=[4], Rx=[7:5], Ry=[10:8], imm8=[15:8], imm11=[15:5]
in_pc  in  DATA_W  PC of in_instr (already incremented)
in_ready  out  1  stage accepts in_instr this cycle
rf_raddr_x  out  3  RF read address = in_instr Rx (combinational)
rf_raddr_y  out  3  RF read address = in_instr Ry (combinational)
rf_rdata_x  in  DATA_W  RF data for rf_raddr_x, same cycle
rf_rdata_y  in  DATA_W  RF data for rf_raddr_y, same cycle
ex_wr  in  1  EX-stage instruction will write Rx
ex_waddr  in  3  EX destination
ex_wdata  in  DATA_W  EX result (invalid when ex_is_ld)
ex_is_ld  in  1  EX instruction is ld (op 5)
wb_wr  in  1  WB writes wb_waddr this cycle
wb_waddr  in  3  WB destination
wb_wdata  in  DATA_W  WB data
wb_ld_r7  in  1  WB writes R7 with wb_r7_data (call)
wb_r7_data  in  DATA_W  return address
ex_stall  in  1  EX cannot accept; hold ID/EX register
flush  in  1  taken branch; discard stage contents and in_instr
out_valid  out  1  ID/EX register holds a real instruction
out_instr  out  16  registered instruction
out_pc  out  DATA_W  registered PC
out_opx  out  DATA_W  resolved Rx operand
out_opy  out  DATA_W  resolved Ry operand
out_imm  out  DATA_W  sign-extended immediate

Behaviour:
- Reset (async): out_valid=0, out_instr=BUBBLE_INSTR, out_pc=0, out_opx=0, out_opy=0, out_imm=0. in_ready is combinational and equals 1 once reset deasserts.
- Source use, by op:
  - 0 mv: reg form reads Ry; imm form reads none.
  - 1 add / 2 sub / 3 cmp: reg form reads Rx and Ry; imm form reads Rx.
  - 4 st: reads Rx and Ry.
  - 5 ld: reads Ry.
  - 6 mvhi: reads Rx.
  - 8/9/10 jumps and 12 call: reg form reads Rx; imm form reads none.
  - Any other op: reads none.
- Immediate:
  - ops 0–6: out_imm = sext(imm8).
  - ops 8/9/10/12: out_imm = sext(imm11)<<1.
  - otherwise: 0.
- Operand priority, per used source s:
  1. EX match (ex_wr && ex_waddr==s, not ld) -> ex_wdata.
  2. WB R7 (wb_ld_r7 && s==7) -> wb_r7_data.
  3. WB match (wb_wr && wb_waddr==s) -> wb_wdata.
  4. Otherwise -> rf_rdata.
- Load-use hazard: in_valid && a used source equals ex_waddr && ex_wr && ex_is_ld.
  - in_ready=0.
  - The ID/EX register loads the bubble (out_valid=0, out_instr=BUBBLE_INSTR).
  - Exactly one bubble per load; the next cycle the value arrives through WB forwarding.
- Timing: one-cycle latency. An instruction accepted at edge N appears on out_* after edge N.
- ex_stall=1: all out_* hold and in_ready=0. Hazard logic is re-evaluated every cycle while held.
- flush=1: next edge loads the bubble and in_ready=1 (fetched word dropped). flush has priority over ex_stall and over hazard.
- in_valid=0 without stall or hazard: the bubble is loaded.
- Unused sources never cause hazards or stalls.
- Register R0 receives no special treatment.

Optional Feature:
CPU_RF_FWD_EN
- Defined: forwarding exactly as above.
- Undefined: no forwarding; operands always come from rf_rdata. Stall (bubble, in_ready=0) while any used source matches an EX write, a WB write, or WB R7. Stall releases the cycle after WB commits, so back-to-back dependency costs 2 bubbles.

Decomposition:
- Package cpu_pkg:
  - opcode enum (OP_MV=0 … OP_CALL=12)
  - instruction field slice localparams
  - BUBBLE_INSTR default
  - typedef id_ex_t struct {valid, instr, pc, opx, opy, imm}
- Sub-module cpu_src_use: combinational op -> {use_x, use_y, imm}. Shared with the write-side decode style.

Test Plan:
- add R1,R2 with RF R1=5, R2=7, no hazards -> next cycle out_opx=5, out_opy=7, out_valid=1.
- EX writing R2=0x1234 (not ld), WB writing R2=0x0001, then sub R3,R2 -> out_opy=0x1234 (EX wins).
- ld R4,[R5] in EX, then add R1,R4 -> one bubble (out_valid=0, in_ready=0), then out_opy = wb_wdata 0xBEEF.
- wb_ld_r7=1 with wb_r7_data=0x0042, then jr R7 -> out_opx=0x0042. Imm jump with imm11=-3 -> out_imm=0xFFFA.
- flush asserted together with ex_stall and a hazard -> out_valid=0 next cycle and in_ready=1. Assert reset mid-stream -> all outputs at reset values immediately.
- Without CPU_RF_FWD_EN: add R1 then add R2,R1 -> two bubbles, then out_opx equals the value committed to R1.
